// File: rtl/dfr_sequencer.sv
// Run sequencer for the DFR core: reservoir clear, warm-up, history capture and
// output-layer matrix multiply, with internal sample counting, watchdog and abort.
module dfr_sequencer #(
  parameter int SAMPLE_CNT_WIDTH = 16,
  parameter int TIMEOUT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES   = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        cfg_mode,
  input  logic [SAMPLE_CNT_WIDTH-1:0] cfg_init_samples,
  input  logic [SAMPLE_CNT_WIDTH-1:0] cfg_num_samples,
  input  logic                        reservoir_valid,
  input  logic                        matrix_multiply_busy,
  output logic                        busy,
  output logic                        dfr_done,
  output logic                        done_pulse,
  output logic                        error,
  output logic [1:0]                  err_code,
  output logic                        reservoir_rst,
  output logic                        matrix_multiply_rst,
  output logic                        reservoir_history_rst,
  output logic                        reservoir_en,
  output logic                        reservoir_history_en,
  output logic                        matrix_multiply_start,
  output logic [SAMPLE_CNT_WIDTH-1:0] history_idx,
  output logic [3:0]                  current_state_out
);
  localparam int CW = SAMPLE_CNT_WIDTH + 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CLEAR    = 4'd1,
    S_ISSUE    = 4'd2,
    S_WAIT     = 4'd3,
    S_MM_START = 4'd4,
    S_MM_WAIT  = 4'd5,
    S_FINISH   = 4'd6,
    S_FAULT    = 4'd7,
    S_ABORT    = 4'd8
  } state_t;

  state_t                      state;
  logic                        mode_q;
  logic [SAMPLE_CNT_WIDTH-1:0] init_q;
  logic [SAMPLE_CNT_WIDTH-1:0] num_q;
  logic [CW-1:0]               sample_cnt;
  logic [TIMEOUT_WIDTH-1:0]    wd;
  logic                        mm_guard;

  logic [CW-1:0] total;
  logic          capture;
  logic          last_sample;
  logic          wd_expire;

  // Counter is one bit wider than the config so init+num never wraps.
  assign total       = CW'(init_q) + CW'(num_q);
  assign capture     = sample_cnt >= CW'(init_q);
  assign last_sample = sample_cnt == (total - CW'(1));
  assign wd_expire   = WD_EN && (wd == WD_LAST);

  assign busy                  = (state != S_IDLE) && (state != S_FAULT);
  assign done_pulse            = state == S_FINISH;
  assign reservoir_rst         = (state == S_CLEAR) || (state == S_ABORT);
  assign matrix_multiply_rst   = (state == S_CLEAR) || (state == S_ABORT);
  assign reservoir_history_rst = state == S_CLEAR;
  assign reservoir_en          = state == S_ISSUE;
  assign matrix_multiply_start = state == S_MM_START;
  assign current_state_out     = state;
  // History strobe must coincide with the valid pulse, so it bypasses the state register.
  assign reservoir_history_en  = (state == S_WAIT) && reservoir_valid && !abort && capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mode_q      <= 1'b0;
      init_q      <= '0;
      num_q       <= '0;
      sample_cnt  <= '0;
      history_idx <= '0;
      wd          <= '0;
      mm_guard    <= 1'b0;
      dfr_done    <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      case (state)
        S_IDLE, S_FAULT: begin
          if (start) begin
            if (cfg_num_samples == '0) begin
              state    <= S_FAULT;
              error    <= 1'b1;
              err_code <= 2'd1;
              dfr_done <= 1'b0;
            end else begin
              mode_q      <= cfg_mode;
              init_q      <= cfg_init_samples;
              num_q       <= cfg_num_samples;
              sample_cnt  <= '0;
              history_idx <= '0;
              wd          <= '0;
              error       <= 1'b0;
              err_code    <= 2'd0;
              dfr_done    <= 1'b0;
              state       <= S_CLEAR;
            end
          end
        end
        S_CLEAR: state <= abort ? S_ABORT : S_ISSUE;
        S_ISSUE: begin
          wd    <= '0;
          state <= abort ? S_ABORT : S_WAIT;
        end
        S_WAIT: begin
          wd <= wd + TIMEOUT_WIDTH'(1);
          if (abort) begin
            state <= S_ABORT;
          end else if (reservoir_valid) begin
            sample_cnt <= sample_cnt + CW'(1);
            if (capture) history_idx <= history_idx + SAMPLE_CNT_WIDTH'(1);
            state <= (last_sample || (mode_q && capture)) ? S_MM_START : S_ISSUE;
          end else if (wd_expire) begin
            state    <= S_FAULT;
            error    <= 1'b1;
            err_code <= 2'd2;
          end
        end
        S_MM_START: begin
          wd       <= '0;
          mm_guard <= 1'b1;
          state    <= abort ? S_ABORT : S_MM_WAIT;
        end
        S_MM_WAIT: begin
          // Guard cycle gives the multiplier one cycle to raise busy after start.
          wd       <= wd + TIMEOUT_WIDTH'(1);
          mm_guard <= 1'b0;
          if (abort) begin
            state <= S_ABORT;
          end else if (!mm_guard && !matrix_multiply_busy) begin
            state <= (sample_cnt == total) ? S_FINISH : S_ISSUE;
          end else if (wd_expire) begin
            state    <= S_FAULT;
            error    <= 1'b1;
            err_code <= 2'd3;
          end
        end
        S_FINISH: begin
          if (abort) begin
            state <= S_ABORT;
          end else begin
            dfr_done <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_ABORT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dfr_sequencer.sv
// Scoreboard bench for dfr_sequencer: expected output events are queued at start
// and popped as the DUT produces them, with latency checks against reservoir/multiplier models.
module tb_dfr_sequencer;
  localparam int SW      = 16;
  localparam int TO      = 8;
  localparam int MM_BUSY = 4;
  localparam int RES_LAT = 1;

  // Event masks: {done, mm_start, hist_en, res_en, hist_rst, mm_rst, res_rst}
  localparam logic [6:0] EV_CLR  = 7'b0000111;
  localparam logic [6:0] EV_ABT  = 7'b0000011;
  localparam logic [6:0] EV_EN   = 7'b0001000;
  localparam logic [6:0] EV_HIST = 7'b0010000;
  localparam logic [6:0] EV_MMS  = 7'b0100000;
  localparam logic [6:0] EV_DONE = 7'b1000000;

  logic          clk = 1'b0;
  logic          rst, start, abort, cfg_mode, reservoir_valid, matrix_multiply_busy;
  logic [SW-1:0] cfg_init_samples, cfg_num_samples;
  logic          busy, dfr_done, done_pulse, error;
  logic [1:0]    err_code;
  logic          reservoir_rst, matrix_multiply_rst, reservoir_history_rst;
  logic          reservoir_en, reservoir_history_en, matrix_multiply_start;
  logic [SW-1:0] history_idx;
  logic [3:0]    current_state_out;

  int tests = 0, fails = 0, cyc = 0;
  logic [6:0] exp_q[$];
  int res_due, mm_s, valid_seen, hist_seen, abort_at;
  int resume_cyc, last_valid_cyc, last_en_cyc;
  bit res_hold;

  dfr_sequencer #(.SAMPLE_CNT_WIDTH(SW), .TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_mode(cfg_mode),
    .cfg_init_samples(cfg_init_samples), .cfg_num_samples(cfg_num_samples),
    .reservoir_valid(reservoir_valid), .matrix_multiply_busy(matrix_multiply_busy),
    .busy(busy), .dfr_done(dfr_done), .done_pulse(done_pulse), .error(error),
    .err_code(err_code), .reservoir_rst(reservoir_rst),
    .matrix_multiply_rst(matrix_multiply_rst), .reservoir_history_rst(reservoir_history_rst),
    .reservoir_en(reservoir_en), .reservoir_history_en(reservoir_history_en),
    .matrix_multiply_start(matrix_multiply_start), .history_idx(history_idx),
    .current_state_out(current_state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  function automatic void push_run(bit mode, int init, int num, int ab);
    exp_q.push_back(EV_CLR);
    for (int i = 0; i < init + num; i++) begin
      exp_q.push_back(EV_EN);
      if (ab == i + 1) begin
        exp_q.push_back(EV_ABT);
        return;
      end
      if (i >= init) exp_q.push_back(EV_HIST);
      if (i == init + num - 1 || (mode && i >= init)) exp_q.push_back(EV_MMS);
    end
    exp_q.push_back(EV_DONE);
  endfunction

  // One clock: drive inputs at negedge from the models, observe 1ns later.
  task automatic step();
    logic [6:0] m, e;
    @(negedge clk);
    cyc++;
    reservoir_valid      = !res_hold && (cyc == res_due);
    abort                = reservoir_valid && (abort_at == valid_seen + 1);
    matrix_multiply_busy = (cyc > mm_s) && (cyc <= mm_s + MM_BUSY);
    #1;
    m = {done_pulse, matrix_multiply_start, reservoir_history_en, reservoir_en,
         reservoir_history_rst, matrix_multiply_rst, reservoir_rst};
    if (m != 7'b0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL event cyc=%0d: got %b, expected no event", cyc, m);
      end else begin
        e = exp_q.pop_front();
        if (m !== e) begin
          fails++;
          $display("FAIL event cyc=%0d: got %b, expected %b", cyc, m, e);
        end
      end
    end
    if (reservoir_en) begin
      tests++;
      if (cyc !== resume_cyc) begin
        fails++;
        $display("FAIL en_latency: reservoir_en at cyc %0d, expected %0d", cyc, resume_cyc);
      end
      last_en_cyc = cyc;
      res_due     = cyc + 1 + RES_LAT;
    end
    if (reservoir_history_en) begin
      tests++;
      if (history_idx !== SW'(hist_seen)) begin
        fails++;
        $display("FAIL hist_idx: history_idx %0d at write, expected %0d", history_idx, hist_seen);
      end
      hist_seen++;
    end
    if (matrix_multiply_start) begin
      tests++;
      if (cyc !== last_valid_cyc + 1) begin
        fails++;
        $display("FAIL mms_latency: start at cyc %0d, expected %0d", cyc, last_valid_cyc + 1);
      end
      mm_s       = cyc;
      resume_cyc = cyc + MM_BUSY + 2;
    end
    if (done_pulse) begin
      tests++;
      if (cyc !== resume_cyc) begin
        fails++;
        $display("FAIL done_latency: done_pulse at cyc %0d, expected %0d", cyc, resume_cyc);
      end
    end
    if (reservoir_valid) begin
      valid_seen++;
      last_valid_cyc = cyc;
      if (!abort) resume_cyc = cyc + 1;
    end
    start = 1'b0;
  endtask

  task automatic begin_run(bit mode, int init, int num, int ab, bit push);
    cfg_mode         = mode;
    cfg_init_samples = SW'(init);
    cfg_num_samples  = SW'(num);
    res_due = -1; mm_s = -100; valid_seen = 0; hist_seen = 0; abort_at = ab;
    last_valid_cyc = -100;
    resume_cyc = cyc + 2;
    if (push) push_run(mode, init, num, ab);
    start = 1'b1;
  endtask

  task automatic run_to_idle(int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (busy && n < budget);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL run_to_idle: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic check_drained(string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected events never seen, next %b", name, exp_q.size(), exp_q[0]);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_mode = 1'b0;
    cfg_init_samples = '0; cfg_num_samples = '0;
    reservoir_valid = 1'b0; matrix_multiply_busy = 1'b0;
    res_hold = 1'b1; res_due = -1; mm_s = -100; abort_at = 0; valid_seen = 0;
    step(); step();
    tests++;
    if ({busy, dfr_done, error, err_code, reservoir_en, matrix_multiply_start} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b code=%0d en=%b mms=%b, expected all 0",
               busy, dfr_done, error, err_code, reservoir_en, matrix_multiply_start);
    end
    rst = 1'b0;
    step();
    tests++;
    if (current_state_out !== 4'd0 || history_idx !== '0) begin
      fails++;
      $display("FAIL reset_state: state=%0d idx=%0d, expected 0/0", current_state_out, history_idx);
    end
    res_hold = 1'b0;
  endtask

  task automatic test_batch();
    begin_run(1'b0, 2, 3, 0, 1'b1);
    step();
    // Config changes after latching must have no effect
    cfg_num_samples = SW'(7); cfg_mode = 1'b1;
    run_to_idle(200);
    check_drained("batch_events");
    tests++;
    if (history_idx !== SW'(3) || dfr_done !== 1'b1 || err_code !== 2'd0) begin
      fails++;
      $display("FAIL batch_end: idx=%0d done=%b code=%0d, expected 3/1/0", history_idx, dfr_done, err_code);
    end
  endtask

  task automatic test_streaming();
    begin_run(1'b1, 1, 3, 0, 1'b1);
    run_to_idle(200);
    check_drained("stream_events");
    tests++;
    if (history_idx !== SW'(3) || dfr_done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stream_end: idx=%0d done=%b busy=%b, expected 3/1/0", history_idx, dfr_done, busy);
    end
  endtask

  task automatic test_timeout();
    res_hold = 1'b1;
    begin_run(1'b0, 0, 2, 0, 1'b0);
    exp_q.push_back(EV_CLR);
    exp_q.push_back(EV_EN);
    run_to_idle(50);
    check_drained("timeout_events");
    tests++;
    if (cyc !== last_en_cyc + 1 + TO) begin
      fails++;
      $display("FAIL timeout_latency: idle at cyc %0d, expected %0d", cyc, last_en_cyc + 1 + TO);
    end
    tests++;
    if (error !== 1'b1 || err_code !== 2'd2 || current_state_out !== 4'd7) begin
      fails++;
      $display("FAIL timeout_fault: err=%b code=%0d state=%0d, expected 1/2/7", error, err_code, current_state_out);
    end
    res_hold = 1'b0;
    begin_run(1'b0, 0, 2, 0, 1'b1);
    run_to_idle(200);
    check_drained("recover_events");
    tests++;
    if (error !== 1'b0 || err_code !== 2'd0 || dfr_done !== 1'b1) begin
      fails++;
      $display("FAIL recover: err=%b code=%0d done=%b, expected 0/0/1", error, err_code, dfr_done);
    end
  endtask

  task automatic test_abort();
    begin_run(1'b0, 1, 3, 2, 1'b1);
    run_to_idle(100);
    check_drained("abort_events");
    tests++;
    if (dfr_done !== 1'b0 || current_state_out !== 4'd0 || history_idx !== '0) begin
      fails++;
      $display("FAIL abort_end: done=%b state=%0d idx=%0d, expected 0/0/0", dfr_done, current_state_out, history_idx);
    end
    abort_at = 0;
  endtask

  task automatic test_bad_config();
    begin_run(1'b0, 4, 0, 0, 1'b0);
    run_to_idle(10);
    for (int i = 0; i < 5; i++) step();
    check_drained("badcfg_events");
    tests++;
    if (error !== 1'b1 || err_code !== 2'd1 || current_state_out !== 4'd7) begin
      fails++;
      $display("FAIL bad_config: err=%b code=%0d state=%0d, expected 1/1/7", error, err_code, current_state_out);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    begin_run(1'b1, 0, 2, 0, 1'b1);
    while (mm_s < 0 && n < 50) begin
      step();
      n++;
    end
    step(); step();
    tests++;
    if (busy !== 1'b1 || current_state_out !== 4'd5) begin
      fails++;
      $display("FAIL pre_reset: busy=%b state=%0d, expected 1/5", busy, current_state_out);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, error, dfr_done, reservoir_en, matrix_multiply_start, reservoir_rst} !== 6'b0 ||
        current_state_out !== 4'd0 || history_idx !== '0) begin
      fails++;
      $display("FAIL async_reset: busy=%b state=%0d idx=%0d, expected 0/0/0", busy, current_state_out, history_idx);
    end
    exp_q.delete();
    mm_s = -100; res_due = -1;
    step();
    rst = 1'b0;
    step(); step();
    tests++;
    if (current_state_out !== 4'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: state=%0d busy=%b, expected 0/0", current_state_out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_batch();
    test_streaming();
    test_timeout();
    test_abort();
    test_bad_config();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
